// File: rtl/vec_mul_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_mul_seq_ctrl_pkg
// Brief    : State encoding and row-width constant for the vec-mul sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package vec_mul_seq_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WLOAD   = 3'd1;
  localparam state_t S_WSETTLE = 3'd2;
  localparam state_t S_STREAM  = 3'd3;
  localparam state_t S_DRAIN   = 3'd4;
  localparam state_t S_DONE    = 3'd5;

  localparam int PARTIAL_SUM_BW_DEF = 20;
  localparam int MATRIX_SIZE_DEF    = 8;
  localparam int ROW_W              = PARTIAL_SUM_BW_DEF * MATRIX_SIZE_DEF;

endpackage
`default_nettype wire

// File: rtl/vec_mul_seq_ctrl_valid_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : valid_delay_line
// Brief    : DEPTH-deep 1-bit valid shift register with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module valid_delay_line #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic i_clr_n,
  input  logic i_din,
  output logic o_tap,
  output logic o_any
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!i_clr_n) r_sr <= '0;
        else          r_sr <= i_din;
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (!i_clr_n) r_sr <= '0;
        else          r_sr <= {r_sr[DEPTH-2:0], i_din};
      end
    end
  endgenerate

  assign o_tap = r_sr[DEPTH-1];
  assign o_any = |r_sr;

endmodule
`default_nettype wire

// File: rtl/vec_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vec_mul_seq_ctrl
// Brief    : Weight-load / address-stream / result-write sequencer for vec_mul.
// Revision : 1.0 - initial release
// ============================================================================
module vec_mul_seq_ctrl
  import vec_mul_seq_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 8,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int PIPE_LATENCY   = 9,
  parameter int W_LATENCY      = 2
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic                                   reuse_weights,
  input  logic [ADDRESSSIZE-1:0]                 src_base,
  input  logic [ADDRESSSIZE-1:0]                 dst_base,
  input  logic [ADDRESSSIZE-1:0]                 num_vecs,
  input  logic                                   fifo_empty,
  output logic                                   fifo_read_enable,
  output logic                                   weight_reload,
  output logic [ADDRESSSIZE-1:0]                 ub_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  result_in,
  output logic                                   res_we,
  output logic [ADDRESSSIZE-1:0]                 res_address,
  output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  res_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err_no_weights
);

  localparam logic [ADDRESSSIZE-1:0] c_addr_one   = {{(ADDRESSSIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDRESSSIZE:0]   c_cnt_one    = {{ADDRESSSIZE{1'b0}}, 1'b1};
  localparam logic [4:0]             c_settle_one = 5'd1;
  localparam logic [4:0]             c_settle_len = 5'(W_LATENCY);

  state_t                 r_state;
  logic [ADDRESSSIZE-1:0] r_src;
  logic [ADDRESSSIZE-1:0] r_dst;
  logic [ADDRESSSIZE-1:0] r_num;
  logic [ADDRESSSIZE:0]   r_issue_cnt;
  logic [ADDRESSSIZE:0]   r_wr_cnt;
  logic [4:0]             r_settle_cnt;

  logic                   w_issue;
  logic                   w_tap;
  logic                   w_pipe_any;
  logic [ADDRESSSIZE:0]   w_num_ext;

  // An address is on ub_address in every STREAM cycle, so that is the issue strobe.
  assign w_issue   = (r_state == S_STREAM);
  assign w_num_ext = {1'b0, r_num};

  valid_delay_line #(
    .DEPTH (PIPE_LATENCY)
  ) u_valid_delay_line (
    .clk     (clk),
    .i_clr_n (rstn),
    .i_din   (w_issue),
    .o_tap   (w_tap),
    .o_any   (w_pipe_any)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state          <= S_IDLE;
      r_src            <= '0;
      r_dst            <= '0;
      r_num            <= '0;
      r_issue_cnt      <= '0;
      r_wr_cnt         <= '0;
      r_settle_cnt     <= '0;
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      ub_address       <= '0;
      res_we           <= 1'b0;
      res_address      <= '0;
      res_data         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_no_weights   <= 1'b0;
    end else begin
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      done             <= 1'b0;
      err_no_weights   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src        <= src_base;
            r_dst        <= dst_base;
            r_num        <= num_vecs;
            r_issue_cnt  <= '0;
            r_wr_cnt     <= '0;
            r_settle_cnt <= '0;
            if (num_vecs == '0) begin
              r_state <= S_DONE;
              busy    <= 1'b1;
              done    <= 1'b1;
            end else if (reuse_weights) begin
              r_state <= S_WSETTLE;
              busy    <= 1'b1;
            end else if (fifo_empty) begin
              err_no_weights <= 1'b1;
            end else begin
              r_state          <= S_WLOAD;
              busy             <= 1'b1;
              fifo_read_enable <= 1'b1;
              weight_reload    <= 1'b1;
            end
          end
        end
        S_WLOAD: begin
          r_state <= S_WSETTLE;
        end
        S_WSETTLE: begin
          // W_LATENCY of 0 still costs one pass through this state.
          if ((r_settle_cnt + c_settle_one) >= c_settle_len) begin
            r_state     <= S_STREAM;
            ub_address  <= r_src;
            r_issue_cnt <= c_cnt_one;
          end else begin
            r_settle_cnt <= r_settle_cnt + c_settle_one;
          end
        end
        S_STREAM: begin
          if (r_issue_cnt == w_num_ext) begin
            r_state <= S_DRAIN;
          end else begin
            ub_address  <= ub_address + c_addr_one;
            r_issue_cnt <= r_issue_cnt + c_cnt_one;
          end
        end
        S_DRAIN: begin
          if ((r_wr_cnt == w_num_ext) && !w_pipe_any) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase

      res_we <= w_tap;
      if (w_tap) begin
        res_data    <= result_in;
        res_address <= r_dst + r_wr_cnt[ADDRESSSIZE-1:0];
        r_wr_cnt    <= r_wr_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vec_mul_seq_ctrl.md
Name: vec_mul_seq_ctrl

Overview:
- Sequencing controller for the vector-multiply datapath. It replaces the ad-hoc valid flip-flop, the 4-bit result counter and the fixed-cycle state machine with one parametrised FSM.
- On start it performs these steps in order:
  - pops one weight set from the Weight FIFO and pulses weight_reload;
  - streams num_vecs consecutive Unified Buffer addresses into the multiplier;
  - tracks each issued vector through a latency-matched valid pipeline;
  - writes each result row to the results SRAM at dst_base + k.
- It sits between the top-level host pins and the SRAM_UnifiedBuffer, Weight_FIFO, vec_mul array and SRAM_Results instances.

Parameters:
- ADDRESSSIZE, 10: width of all SRAM addresses and of num_vecs.
- MATRIX_SIZE, 8: number of result lanes per row.
- PARTIAL_SUM_BW, 20: width of each result lane.
- PIPE_LATENCY, 9: cycles from ub_address driven to the matching row being valid on result_in (range 1..32).
- W_LATENCY, 2: idle cycles after the weight_reload pulse before the first UB address is issued (range 0..15).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- reuse_weights  in  1  sampled with start; 1 = skip the FIFO pop and reload, keep current weights
- src_base  in  ADDRESSSIZE  first UB address
- dst_base  in  ADDRESSSIZE  first results-SRAM address
- num_vecs  in  ADDRESSSIZE  number of vectors in the job
- fifo_empty  in  1  Weight FIFO empty flag
- fifo_read_enable  out  1  one-cycle FIFO pop
- weight_reload  out  1  one-cycle latch of the FIFO head into the array
- ub_address  out  ADDRESSSIZE  UB read address
- result_in  in  PARTIAL_SUM_BW*MATRIX_SIZE  array output row
- res_we  out  1  results-SRAM write enable
- res_address  out  ADDRESSSIZE  results-SRAM address
- res_data  out  PARTIAL_SUM_BW*MATRIX_SIZE  registered copy of result_in
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err_no_weights  out  1  one-cycle pulse: job rejected because the FIFO was empty

Behaviour:
- Reset: the following are all 0 and the FSM is in IDLE.
  - outputs: fifo_read_enable, weight_reload, ub_address, res_we, res_address, res_data, busy, done, err_no_weights;
  - internal state: the valid pipeline and all counters.
- Reset mid-job: the job is aborted; the valid pipeline is cleared, so no res_we occurs after reset.
- Job parameters: src_base, dst_base, num_vecs and reuse_weights are latched on an accepted start. Later changes to these inputs do not affect the running job.
- start while busy is ignored.
- FSM states: IDLE, WLOAD, WSETTLE, STREAM, DRAIN, DONE.
- IDLE + start:
  - num_vecs==0: go to DONE. No FIFO pop, no writes.
  - reuse_weights==1: go to WSETTLE. Skipping WLOAD still honours W_LATENCY.
  - fifo_empty==1: stay in IDLE and pulse err_no_weights next cycle.
  - otherwise: go to WLOAD.
- WLOAD: lasts 1 cycle. fifo_read_enable=1 and weight_reload=1, both registered. Next state is WSETTLE.
- WSETTLE: lasts W_LATENCY cycles, then STREAM. With W_LATENCY=0 it is passed through in 1 cycle.
- STREAM: lasts exactly num_vecs cycles.
  - ub_address = src_base + i for i = 0..num_vecs-1, one address per cycle with no gaps.
  - Address addition is modulo 2^ADDRESSSIZE, i.e. it wraps.
  - Each issued address shifts a 1 into the PIPE_LATENCY-deep valid pipeline.
  - After the last address, go to DRAIN.
  - ub_address holds its last value outside STREAM.
- Write path:
  - When the pipeline tap is 1 (result_in valid for vector k), on the next edge: res_data <= result_in, res_address <= dst_base + k (wrapping), res_we <= 1.
  - Net latency from ub_address to res_we = PIPE_LATENCY + 1 cycles.
  - Writes occur in issue order; k increments per write.
- DRAIN: wait until the write count equals num_vecs and the pipeline is empty, then go to DONE.
- DONE: lasts 1 cycle. done=1, busy=1. Next state is IDLE. A new start is accepted from the following cycle.
- busy and res_we reflect only the current job; no writes are issued outside a job.
- num_vecs = 2^ADDRESSSIZE-1 is legal. Counters are ADDRESSSIZE+1 bits wide, so there is no premature termination.

Decomposition:
- Shared package holds:
  - the state encoding (localparams S_IDLE..S_DONE);
  - the ROW_W = PARTIAL_SUM_BW*MATRIX_SIZE constant.
- One sub-module, valid_delay_line: a PIPE_LATENCY-deep 1-bit shift register with synchronous active-low clear.
- Counters and the FSM remain in vec_mul_seq_ctrl.

Test Plan:
- Basic job.
  - Stimulus: FIFO non-empty, start with src_base=4, dst_base=16, num_vecs=3, W_LATENCY=2, PIPE_LATENCY=9.
  - Response: fifo_read_enable and weight_reload high in the cycle after start; ub_address = 4, 5, 6 on consecutive cycles starting 4 cycles after start (WLOAD 1 + WSETTLE 2 + 1); res_we at res_address = 16, 17, 18, each 10 cycles after its ub_address, with res_data equal to the result_in rows; done once; busy low the next cycle.
- Empty FIFO.
  - Stimulus: fifo_empty=1, start with reuse_weights=0.
  - Response: err_no_weights pulses once; busy stays 0; no pop, no writes.
- Reuse weights.
  - Stimulus: reuse_weights=1, num_vecs=2.
  - Response: fifo_read_enable and weight_reload never asserted; 2 writes; done.
- Wrap-around and zero length.
  - Stimulus: src_base=1022, dst_base=1023, num_vecs=3, ADDRESSSIZE=10.
  - Response: ub_address = 1022, 1023, 0; res_address = 1023, 0, 1.
  - Then num_vecs=0: done one cycle after start, no writes.
- Start while busy and back-to-back jobs.
  - Stimulus: start pulsed during STREAM; then a second start the cycle after done.
  - Response: the pulse during STREAM is ignored; the second job runs fully with correct addresses.
- Reset mid-job.
  - Stimulus: rstn=0 for 1 cycle during DRAIN with 5 rows still in flight.
  - Response: all outputs 0 on the next edge; zero subsequent res_we; a fresh job after reset is correct.
